// File: rtl/fetch_pkg.sv
// Shared types for the fetch aligner: buffered fetch word, aligner state and
// the RVC length decode.
package fetch_pkg;

    localparam int INS_W = 32;
    localparam int HW_W  = 16;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } fetch_word_t;

    typedef enum logic [1:0] {
        S_FRESH = 2'd0,
        S_OFF0  = 2'd1,
        S_OFF2  = 2'd2
    } algn_state_e;

    // Any halfword whose low two bits are not 2'b11 starts a 16-bit instruction.
    function automatic logic is_rvc(input logic [HW_W-1:0] hw);
        return hw[1:0] != 2'b11;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Fetch-word FIFO with registered storage and fall-through read; exposes the
// head entry and the one behind it so the aligner can stitch straddling words.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush_i,
    input  logic                       push_i,
    input  fetch_word_t                word_i,
    input  logic                       pop_i,
    output fetch_word_t                head_o,
    output fetch_word_t                next_o,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    fetch_word_t        mem_q [DEPTH];
    logic [PTR_W-1:0]   wptr_q, wptr_d;
    logic [PTR_W-1:0]   rptr_q, rptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               do_push, do_pop;

    assign do_push = push_i && !flush_i;
    assign do_pop  = pop_i  && !flush_i;

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (flush_i) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
        end else begin
            if (do_push) wptr_d = wptr_q + PTR_W'(1);
            if (do_pop)  rptr_d = rptr_q + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // NOTE: non-blocking assignments in clocked blocks so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    // NOTE: storage is not reset; count_q gates every read, so stale entries are never observed.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wptr_q] <= word_i;
    end

    assign head_o  = mem_q[rptr_q];
    assign next_o  = mem_q[rptr_q + PTR_W'(1)];
    assign count_o = count_q;

endmodule

// File: rtl/fetch_aligner.sv
// Carves buffered 32-bit fetch words into whole RV32IC instructions and hands
// them to decode one per cycle over valid/ready; flush restarts the stream.
module fetch_aligner
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              fq_valid,
    output logic              fq_ready,
    input  logic [31:0]       fq_addr,
    input  logic [31:0]       fq_data,
    output logic              ins_valid,
    input  logic              ins_ready,
    output logic [INS_W-1:0]  ins_data,
    output logic [31:0]       ins_pc,
    output logic              ins_cmp
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    algn_state_e       state_q, state_d;
    fetch_word_t       head, next;
    logic [CNT_W-1:0]  count;
    logic              head_v, next_v;
    logic              eff_off, hw_cmp, handshake, pop;
    logic [HW_W-1:0]   hw;

    assign fq_ready = (count < CNT_W'(DEPTH));
    assign head_v   = (count != '0);
    assign next_v   = (count >= CNT_W'(2));

    fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush_i (flush),
        .push_i  (fq_valid && fq_ready),
        .word_i  ('{addr: fq_addr, data: fq_data}),
        .pop_i   (pop),
        .head_o  (head),
        .next_o  (next),
        .count_o (count)
    );

    // A fresh stream takes its starting halfword from the head word's address.
    assign eff_off   = (state_q == S_FRESH) ? head.addr[1] : (state_q == S_OFF2);
    assign hw        = eff_off ? head.data[31:16] : head.data[15:0];
    assign hw_cmp    = is_rvc(hw);
    assign ins_valid = head_v && (!eff_off || hw_cmp || next_v);
    assign handshake = ins_valid && ins_ready;
    // Only a compressed instruction in the low half leaves the head word partly unconsumed.
    assign pop       = handshake && (eff_off || !hw_cmp);

    // NOTE: defaults first in always_comb so no path leaves an output unassigned (no latches).
    always_comb begin
        ins_data = '0;
        ins_pc   = '0;
        ins_cmp  = 1'b0;
        if (ins_valid) begin
            ins_cmp = hw_cmp;
            ins_pc  = {head.addr[31:2], eff_off, 1'b0};
            if (hw_cmp)
                ins_data = {16'h0, hw};
            else if (!eff_off)
                ins_data = head.data;
            else
                ins_data = {next.data[15:0], head.data[31:16]};
        end
    end

    always_comb begin
        state_d = state_q;
        if (flush)
            state_d = S_FRESH;
        else if (handshake)
            state_d = (eff_off ^ hw_cmp) ? S_OFF2 : S_OFF0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_FRESH;
        else        state_q <= state_d;
    end

    logic unused_bits;
    assign unused_bits = ^{head.addr[0], next.addr, next.data[31:16]};

endmodule
